// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: state encoding and default limits
// shared by the IF/MEM single-port bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE     = 3'd0,
        ARB_IF_BUSY  = 3'd1,
        ARB_MEM_BUSY = 3'd2,
        ARB_IF_DRAIN = 3'd3,
        ARB_DONE     = 3'd4
    } arb_state_t;

    localparam int ARB_FAIR_MAX = 4;
    localparam int ARB_TIMEOUT  = 255;

    localparam logic [31:0] ZERO_WORD = 32'h0;
    localparam logic [3:0]  SEL_WORD  = 4'hF;

endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares one single-port bus between IF (fetch) and MEM
// (load/store), returns read data and raises per-stage stall requests.
//   clk, rst           : clock, synchronous active-high reset
//   flush              : pipeline flush, drains an in-flight fetch
//   if_*               : fetch request / instruction return / stall
//   mem_*              : load-store request / data return / stall
//   bus_*              : single-port bus master side (req held to ack)
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int FAIR_MAX = ARB_FAIR_MAX,
    parameter int TIMEOUT  = ARB_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    output logic        if_err,
    output logic        if_stallreq,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [3:0]  mem_sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ack,
    output logic        mem_err,
    output logic        mem_stallreq,
    output logic        bus_req,
    output logic        bus_we,
    output logic [3:0]  bus_sel,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack
);

    localparam int FW = (FAIR_MAX < 1) ? 1 : $clog2(FAIR_MAX + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    arb_state_t    state;
    logic [FW-1:0] fair_cnt;
    logic [TW-1:0] tmo_cnt;

    logic fair_hit;
    logic tmo_hit;
    logic grant_mem;
    logic grant_if;

    // IF is forced through once MEM has won FAIR_MAX times in a row
    // while IF was waiting.
    assign fair_hit  = if_req && (fair_cnt == FW'(FAIR_MAX));
    assign grant_mem = mem_req && !fair_hit;
    assign grant_if  = if_req && !flush && !grant_mem;

    // This cycle is the last one allowed without bus_ack.
    assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

    assign if_stallreq  = if_req & ~if_ack;
    assign mem_stallreq = mem_req & ~mem_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ARB_IDLE;
            fair_cnt  <= '0;
            tmo_cnt   <= '0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_sel   <= '0;
            bus_addr  <= ZERO_WORD;
            bus_wdata <= ZERO_WORD;
            if_rdata  <= ZERO_WORD;
            if_ack    <= 1'b0;
            if_err    <= 1'b0;
            mem_rdata <= ZERO_WORD;
            mem_ack   <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            if_ack  <= 1'b0;
            if_err  <= 1'b0;
            mem_ack <= 1'b0;
            mem_err <= 1'b0;
            unique case (state)
                ARB_IDLE: begin
                    unique case (1'b1)
                        grant_mem: begin
                            state     <= ARB_MEM_BUSY;
                            tmo_cnt   <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= mem_we;
                            bus_sel   <= mem_sel;
                            bus_addr  <= mem_addr;
                            bus_wdata <= mem_wdata;
                            fair_cnt  <= if_req ? fair_cnt + FW'(1) : '0;
                        end
                        grant_if: begin
                            state     <= ARB_IF_BUSY;
                            tmo_cnt   <= '0;
                            bus_req   <= 1'b1;
                            bus_we    <= 1'b0;
                            bus_sel   <= SEL_WORD;
                            bus_addr  <= if_addr;
                            bus_wdata <= ZERO_WORD;
                            fair_cnt  <= '0;
                        end
                        default: ;
                    endcase
                end
                ARB_IF_BUSY: begin
                    if (bus_ack) begin
                        bus_req  <= 1'b0;
                        if_rdata <= bus_rdata;
                        if_ack   <= 1'b1;
                        state    <= ARB_DONE;
                    end else if (tmo_hit) begin
                        bus_req  <= 1'b0;
                        if_rdata <= ZERO_WORD;
                        if_ack   <= 1'b1;
                        if_err   <= 1'b1;
                        state    <= ARB_DONE;
                    end else if (flush) begin
                        // Bus cannot be abandoned mid-cycle; drain it.
                        state   <= ARB_IF_DRAIN;
                        tmo_cnt <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ARB_MEM_BUSY: begin
                    if (bus_ack) begin
                        bus_req   <= 1'b0;
                        mem_rdata <= bus_we ? ZERO_WORD : bus_rdata;
                        mem_ack   <= 1'b1;
                        state     <= ARB_DONE;
                    end else if (tmo_hit) begin
                        bus_req   <= 1'b0;
                        mem_rdata <= ZERO_WORD;
                        mem_ack   <= 1'b1;
                        mem_err   <= 1'b1;
                        state     <= ARB_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ARB_IF_DRAIN: begin
                    if (bus_ack || tmo_hit) begin
                        bus_req <= 1'b0;
                        state   <= ARB_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                ARB_DONE: begin
                    state <= ARB_IDLE;
                end
                default: begin
                    state   <= ARB_IDLE;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: self-checking bench for bus_arbiter with a
// behavioural bus slave and a transaction-level arbitration model.
module tb_bus_arbiter;

    localparam int FAIR_MAX = 4;
    localparam int TIMEOUT  = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ack;
    logic        if_err;
    logic        if_stallreq;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        mem_err;
    logic        mem_stallreq;
    logic        bus_req;
    logic        bus_we;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    logic        slave_ack;
    logic        stray_ack;
    logic [31:0] slave_last;
    int          slave_lat = 0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign bus_ack = slave_ack | stray_ack;

    bus_arbiter #(
        .FAIR_MAX(FAIR_MAX),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .if_req      (if_req),
        .if_addr     (if_addr),
        .if_rdata    (if_rdata),
        .if_ack      (if_ack),
        .if_err      (if_err),
        .if_stallreq (if_stallreq),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_sel     (mem_sel),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .mem_err     (mem_err),
        .mem_stallreq(mem_stallreq),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_sel     (bus_sel),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_rdata   (bus_rdata),
        .bus_ack     (bus_ack)
    );

    // Bus slave: slave_lat >= 0 fixed wait, -1 never acks, -2 random 0..3.
    task automatic slave_fire();
        slave_last = $urandom;
        bus_rdata  = slave_last;
        slave_ack  = 1'b1;
    endtask

    initial begin : slave
        bit busy;
        int cnt;
        busy       = 1'b0;
        cnt        = 0;
        slave_ack  = 1'b0;
        bus_rdata  = '0;
        slave_last = '0;
        forever begin
            @(posedge clk);
            #1;
            if (slave_ack) begin
                slave_ack = 1'b0;
                busy      = 1'b0;
            end else if (busy && !bus_req) begin
                busy = 1'b0;
            end else if (!busy && bus_req) begin
                busy = 1'b1;
                if (slave_lat == -1) cnt = -1;
                else if (slave_lat == -2) cnt = $urandom_range(0, 3);
                else cnt = slave_lat;
                if (cnt == 0) slave_fire();
            end else if (busy && cnt > 0) begin
                cnt--;
                if (cnt == 0) slave_fire();
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        flush     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_sel   = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        stray_ack = 1'b0;
        slave_lat = 0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic new_mem();
        mem_req   = 1'b1;
        mem_addr  = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
        mem_we    = 1'($urandom_range(0, 1));
        mem_sel   = 4'($urandom_range(1, 15));
        mem_wdata = $urandom;
    endtask

    task automatic wait_grant(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus_req) begin
                ok = 1'b1;
                break;
            end
            cyc();
        end
    endtask

    task automatic wait_ack(input bit is_if, input int budget,
                            output bit ok, output int n);
        ok = 1'b0;
        n  = 0;
        for (int i = 0; i < budget; i++) begin
            cyc();
            n++;
            if (is_if ? if_ack : mem_ack) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if (bus_req !== 1'b0) begin
            $display("FAIL reset_bus_req got %b want 0", bus_req);
            fails++;
        end
        tests++;
        if ({bus_we, bus_sel, bus_addr, bus_wdata} !== 69'h0) begin
            $display("FAIL reset_bus_fields got %h want 0",
                     {bus_we, bus_sel, bus_addr, bus_wdata});
            fails++;
        end
        tests++;
        if ({if_ack, if_err, if_rdata, if_stallreq} !== 35'h0) begin
            $display("FAIL reset_if_out got %h want 0",
                     {if_ack, if_err, if_rdata, if_stallreq});
            fails++;
        end
        tests++;
        if ({mem_ack, mem_err, mem_rdata, mem_stallreq} !== 35'h0) begin
            $display("FAIL reset_mem_out got %h want 0",
                     {mem_ack, mem_err, mem_rdata, mem_stallreq});
            fails++;
        end
    endtask

    task automatic test_single_fetch();
        bit ok;
        int n;
        do_reset();
        slave_lat = 2;
        if_addr   = 32'h0000_0100;
        if_req    = 1'b1;
        wait_grant(5, ok);
        tests++;
        if ({ok, bus_we, bus_sel, bus_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
            $display("FAIL fetch_grant got %h want %h",
                     {ok, bus_we, bus_sel, bus_addr},
                     {1'b1, 1'b0, 4'hF, 32'h100});
            fails++;
        end
        wait_ack(1'b1, 10, ok, n);
        tests++;
        if ({ok, n} !== {1'b1, 32'd3}) begin
            $display("FAIL fetch_latency got ok=%b n=%0d want ok=1 n=3", ok, n);
            fails++;
        end
        tests++;
        if ({if_rdata, if_err, if_stallreq, bus_req} !==
            {slave_last, 1'b0, 1'b0, 1'b0}) begin
            $display("FAIL fetch_data got %h/%b/%b/%b want %h/0/0/0",
                     if_rdata, if_err, if_stallreq, bus_req, slave_last);
            fails++;
        end
        if_req = 1'b0;
        cyc();
        tests++;
        if (if_ack !== 1'b0) begin
            $display("FAIL fetch_ack_pulse got %b want 0", if_ack);
            fails++;
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        int n;
        int low;
        logic [31:0] exp;
        do_reset();
        slave_lat = -2;
        if_addr   = $urandom & 32'h7FFF_FFFC;
        if_req    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b0;
        mem_sel   = 4'hF;
        mem_addr  = 32'h80;
        mem_wdata = $urandom;
        wait_grant(5, ok);
        tests++;
        if ({ok, bus_we, bus_addr} !== {1'b1, 1'b0, 32'h80}) begin
            $display("FAIL simul_mem_first got %h want %h",
                     {ok, bus_we, bus_addr}, {1'b1, 1'b0, 32'h80});
            fails++;
        end
        low = 0;
        ok  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (!if_stallreq) low++;
            cyc();
            if (mem_ack) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if ({ok, mem_rdata, if_stallreq} !== {1'b1, slave_last, 1'b1}) begin
            $display("FAIL simul_mem_ack got %b/%h/%b want 1/%h/1",
                     ok, mem_rdata, if_stallreq, slave_last);
            fails++;
        end
        tests++;
        if (low !== 0) begin
            $display("FAIL simul_if_stall got %0d low cycles want 0", low);
            fails++;
        end
        mem_req = 1'b0;
        wait_grant(6, ok);
        tests++;
        if ({ok, bus_sel, bus_addr} !== {1'b1, 4'hF, if_addr}) begin
            $display("FAIL simul_if_second got %h want %h",
                     {ok, bus_sel, bus_addr}, {1'b1, 4'hF, if_addr});
            fails++;
        end
        wait_ack(1'b1, 10, ok, n);
        exp = slave_last;
        tests++;
        if ({ok, if_rdata} !== {1'b1, exp}) begin
            $display("FAIL simul_if_data got %b/%h want 1/%h", ok, if_rdata, exp);
            fails++;
        end
        if_req = 1'b0;
        cyc();
    endtask

    task automatic test_fairness();
        bit   ok;
        int   n;
        int   waits;
        logic got_m;
        logic exp_m;
        do_reset();
        slave_lat = -2;
        waits     = 0;
        if_addr   = $urandom & 32'h7FFF_FFFC;
        if_req    = 1'b1;
        new_mem();
        for (int k = 0; k < 6; k++) begin
            wait_grant(10, ok);
            tests++;
            if (ok !== 1'b1) begin
                $display("FAIL fair_grant %0d got none want grant", k);
                fails++;
                break;
            end
            exp_m = (waits != FAIR_MAX);
            waits = exp_m ? waits + 1 : 0;
            got_m = bus_addr[31];
            tests++;
            if (got_m !== exp_m) begin
                $display("FAIL fair_order grant %0d got mem=%b want mem=%b",
                         k, got_m, exp_m);
                fails++;
            end
            wait_ack(!got_m, 10, ok, n);
            tests++;
            if (ok !== 1'b1) begin
                $display("FAIL fair_ack %0d got none want ack", k);
                fails++;
                break;
            end
            if (got_m) new_mem();
            else if_addr = $urandom & 32'h7FFF_FFFC;
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
        cyc();
        cyc();
    endtask

    task automatic test_flush();
        bit ok;
        int n;
        int held;
        bit ack_seen;
        logic [31:0] na;
        do_reset();
        slave_lat = 3;
        if_addr   = $urandom & 32'h7FFF_FFFC;
        if_req    = 1'b1;
        wait_grant(5, ok);
        tests++;
        if ({ok, bus_addr} !== {1'b1, if_addr}) begin
            $display("FAIL flush_grant got %h want %h",
                     {ok, bus_addr}, {1'b1, if_addr});
            fails++;
        end
        flush  = 1'b1;
        if_req = 1'b0;
        cyc();
        flush    = 1'b0;
        held     = 0;
        ack_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (if_ack) ack_seen = 1'b1;
            if (!bus_req) break;
            held++;
            cyc();
        end
        tests++;
        if (held !== 3) begin
            $display("FAIL flush_drain_hold got %0d want 3", held);
            fails++;
        end
        na        = $urandom & 32'h7FFF_FFFC;
        if_addr   = na;
        if_req    = 1'b1;
        slave_lat = 0;
        cyc();
        if (if_ack) ack_seen = 1'b1;
        tests++;
        if ({bus_req, bus_addr} !== {1'b1, na}) begin
            $display("FAIL flush_regrant got %h want %h",
                     {bus_req, bus_addr}, {1'b1, na});
            fails++;
        end
        tests++;
        if (ack_seen !== 1'b0) begin
            $display("FAIL flush_no_ack got %b want 0", ack_seen);
            fails++;
        end
        wait_ack(1'b1, 5, ok, n);
        tests++;
        if ({ok, if_rdata} !== {1'b1, slave_last}) begin
            $display("FAIL flush_next_data got %b/%h want 1/%h",
                     ok, if_rdata, slave_last);
            fails++;
        end
        if_req = 1'b0;
        cyc();
    endtask

    task automatic test_timeout();
        bit ok;
        int n;
        bit early;
        logic [31:0] wd;
        do_reset();
        slave_lat = -1;
        wd        = $urandom;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_sel   = 4'h3;
        mem_addr  = 32'h8000_0040;
        mem_wdata = wd;
        wait_grant(5, ok);
        tests++;
        if ({ok, bus_we, bus_sel, bus_wdata} !== {1'b1, 1'b1, 4'h3, wd}) begin
            $display("FAIL tmo_grant got %h want %h",
                     {ok, bus_we, bus_sel, bus_wdata}, {1'b1, 1'b1, 4'h3, wd});
            fails++;
        end
        n     = 0;
        early = 1'b0;
        while (bus_req && n < 300) begin
            if (mem_ack) early = 1'b1;
            n++;
            cyc();
        end
        tests++;
        if ({early, n} !== {1'b0, TIMEOUT}) begin
            $display("FAIL tmo_busy_cycles got %0d early=%b want %0d early=0",
                     n, early, TIMEOUT);
            fails++;
        end
        tests++;
        if ({mem_ack, mem_err, mem_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            $display("FAIL tmo_err_ack got %b/%b/%h want 1/1/0",
                     mem_ack, mem_err, mem_rdata);
            fails++;
        end
        mem_req = 1'b0;
        cyc();
        tests++;
        if ({mem_ack, mem_err} !== 2'b00) begin
            $display("FAIL tmo_ack_pulse got %b want 00", {mem_ack, mem_err});
            fails++;
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int bad;
        do_reset();
        slave_lat = -1;
        new_mem();
        wait_grant(5, ok);
        cyc();
        cyc();
        rst     = 1'b1;
        mem_req = 1'b0;
        cyc();
        tests++;
        if ({ok, bus_req, if_ack, mem_ack} !== 4'b1000) begin
            $display("FAIL rstmid_drop got %b want 1000",
                     {ok, bus_req, if_ack, mem_ack});
            fails++;
        end
        rst       = 1'b0;
        stray_ack = 1'b1;
        cyc();
        stray_ack = 1'b0;
        bad       = 0;
        for (int i = 0; i < 4; i++) begin
            if (if_ack || mem_ack || bus_req) bad++;
            cyc();
        end
        tests++;
        if (bad !== 0) begin
            $display("FAIL rstmid_stray_ack got %0d bad cycles want 0", bad);
            fails++;
        end
    endtask

    // Random traffic against a transaction-level model: MEM wins unless
    // IF has already watched FAIR_MAX consecutive MEM grants.
    task automatic test_random();
        bit   pi, pm, pbr, exp_m, owner_m;
        int   waits, age_i, age_m;
        logic [31:0] exp_d;
        do_reset();
        slave_lat = -2;
        waits     = 0;
        pi        = 1'b0;
        pm        = 1'b0;
        pbr       = 1'b0;
        owner_m   = 1'b0;
        age_i     = 0;
        age_m     = 0;
        for (int c = 0; c < 700; c++) begin
            if (bus_req && !pbr) begin
                exp_m = pm && !(pi && waits == FAIR_MAX);
                tests++;
                if (!pm && !pi) begin
                    $display("FAIL rnd_spurious_grant got addr %h want none",
                             bus_addr);
                    fails++;
                end else if (exp_m) begin
                    if ({bus_we, bus_sel, bus_addr, bus_wdata} !==
                        {mem_we, mem_sel, mem_addr, mem_wdata}) begin
                        $display("FAIL rnd_mem_grant got %h want %h",
                                 {bus_we, bus_sel, bus_addr, bus_wdata},
                                 {mem_we, mem_sel, mem_addr, mem_wdata});
                        fails++;
                    end
                    waits   = pi ? waits + 1 : 0;
                    owner_m = 1'b1;
                end else begin
                    if ({bus_we, bus_sel, bus_addr} !== {1'b0, 4'hF, if_addr}) begin
                        $display("FAIL rnd_if_grant got %h want %h",
                                 {bus_we, bus_sel, bus_addr},
                                 {1'b0, 4'hF, if_addr});
                        fails++;
                    end
                    waits   = 0;
                    owner_m = 1'b0;
                end
            end
            tests++;
            if ({if_stallreq, mem_stallreq} !==
                {if_req && !if_ack, mem_req && !mem_ack}) begin
                $display("FAIL rnd_stall got %b want %b",
                         {if_stallreq, mem_stallreq},
                         {if_req && !if_ack, mem_req && !mem_ack});
                fails++;
            end
            if (if_ack) begin
                tests++;
                if ({owner_m, mem_ack, if_err, if_rdata} !==
                    {1'b0, 1'b0, 1'b0, slave_last}) begin
                    $display("FAIL rnd_if_ack got %b/%b/%b/%h want 0/0/0/%h",
                             owner_m, mem_ack, if_err, if_rdata, slave_last);
                    fails++;
                end
                age_i = 0;
                if (c < 600 && $urandom_range(0, 1) == 1)
                    if_addr = $urandom & 32'h7FFF_FFFC;
                else
                    if_req = 1'b0;
            end
            if (mem_ack) begin
                exp_d = mem_we ? 32'h0 : slave_last;
                tests++;
                if ({owner_m, mem_err, mem_rdata} !== {1'b1, 1'b0, exp_d}) begin
                    $display("FAIL rnd_mem_ack got %b/%b/%h want 1/0/%h",
                             owner_m, mem_err, mem_rdata, exp_d);
                    fails++;
                end
                age_m = 0;
                if (c < 600 && $urandom_range(0, 1) == 1) new_mem();
                else mem_req = 1'b0;
            end
            if (!if_req && c < 600 && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom & 32'h7FFF_FFFC;
            end
            if (!mem_req && c < 600 && $urandom_range(0, 2) == 0) new_mem();
            age_i = if_req ? age_i + 1 : 0;
            age_m = mem_req ? age_m + 1 : 0;
            if (age_i > 60 || age_m > 60) begin
                tests++;
                fails++;
                $display("FAIL rnd_starve got ages %0d/%0d want <= 60",
                         age_i, age_m);
                break;
            end
            pi  = if_req;
            pm  = mem_req;
            pbr = bus_req;
            cyc();
        end
        tests++;
        if ({if_req, mem_req, bus_req} !== 3'b000) begin
            $display("FAIL rnd_drain got %b want 000",
                     {if_req, mem_req, bus_req});
            fails++;
        end
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        stray_ack = 1'b0;
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_fairness();
        test_flush();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
